// File: rtl/sd_piso_serializer.sv
// sd_piso_serializer: parallel-in/serial-out shifter for the SD CMD/DAT pads, MSB first on LANES lanes.
// Latency: beat 0 drives one cycle after start is accepted; done_o pulses one cycle after the last beat.
// Backpressure: none; load_i/start_i outside IDLE are dropped and flagged on ovr_o. Define SER_CRC_EN for per-lane CRC + end bit.
module sd_piso_serializer #(
    parameter int FRAME_W = 48,
    parameter int LANES   = 1,
    parameter int CNT_W   = 6,
    parameter int CRC_W   = 7
) (
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   beats_i,
    output logic [LANES-1:0]   serial_o,
    output logic               oe_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovr_o
);

    localparam int                NBEATS    = FRAME_W / LANES;
    localparam logic [CNT_W-1:0]  MAX_BEATS = CNT_W'(NBEATS);

    // Elaboration-time guard: frame must split evenly into lanes and the beat
    // counter must hold payload + CRC + end beat without wrapping.
    if ((FRAME_W % LANES) != 0) begin : g_bad_lanes
        $error("sd_piso_serializer: FRAME_W must be a multiple of LANES");
    end
    if ((2 ** CNT_W) <= (NBEATS + CRC_W + 1)) begin : g_bad_cnt_w
        $error("sd_piso_serializer: CNT_W too narrow for FRAME_W/LANES + CRC_W + 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
`ifdef SER_CRC_EN
        ST_CRC   = 3'd2,
        ST_END   = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic [CNT_W-1:0]   beats_eff;
    logic [LANES-1:0]   serial_d;
    logic               oe_d;
    logic               busy_d;
    logic               done_d;
    logic               ovr_d;
    logic               req_any;
    logic               last_payload;

`ifdef SER_CRC_EN
    // Polynomial without the implicit top term: CRC16-CCITT for DAT, CRC7 for CMD.
    localparam logic [CRC_W-1:0] CRC_POLY = (CRC_W == 16) ? CRC_W'(16'h1021) : CRC_W'(7'h09);

    logic [LANES-1:0][CRC_W-1:0] crc_q, crc_d;
    logic                        last_crc;

    // One serial CRC step: feedback is the outgoing bit xor the CRC MSB.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb       = b ^ c[CRC_W-1];
        crc_step = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    // CRC occupies beats B .. B+CRC_W-1 of the same counter.
    assign last_crc = (count_q == (beats_q + CNT_W'(CRC_W - 1)));
`endif

    // Zero or oversize beat requests fall back to the full frame.
    assign beats_eff    = ((beats_i == '0) || (beats_i > MAX_BEATS)) ? MAX_BEATS : beats_i;
    assign req_any      = load_i | start_i;
    assign last_payload = (count_q == (beats_q - CNT_W'(1)));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        count_d  = count_q;
        beats_d  = beats_q;
        serial_d = '1;
        oe_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        ovr_d    = 1'b0;
`ifdef SER_CRC_EN
        crc_d    = crc_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (load_i) begin
                    shreg_d = frame_i;
                end
                if (start_i) begin
                    beats_d = beats_eff;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
`ifdef SER_CRC_EN
                    crc_d   = '0;
`endif
                end
            end
            ST_SHIFT: begin
                ovr_d    = req_any;
                busy_d   = 1'b1;
                oe_d     = 1'b1;
                serial_d = shreg_q[FRAME_W-1 -: LANES];
                shreg_d  = shreg_q << LANES;
                count_d  = count_q + CNT_W'(1);
`ifdef SER_CRC_EN
                for (int l = 0; l < LANES; l++) begin
                    crc_d[l] = crc_step(crc_q[l], shreg_q[FRAME_W-LANES+l]);
                end
                if (last_payload) begin
                    state_d = ST_CRC;
                end
`else
                if (last_payload) begin
                    state_d = ST_DONE;
                end
`endif
            end
`ifdef SER_CRC_EN
            ST_CRC: begin
                ovr_d   = req_any;
                busy_d  = 1'b1;
                oe_d    = 1'b1;
                count_d = count_q + CNT_W'(1);
                for (int l = 0; l < LANES; l++) begin
                    serial_d[l] = crc_q[l][CRC_W-1];
                    crc_d[l]    = {crc_q[l][CRC_W-2:0], 1'b0};
                end
                if (last_crc) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                ovr_d    = req_any;
                busy_d   = 1'b1;
                oe_d     = 1'b1;
                serial_d = '1;
                state_d  = ST_DONE;
            end
`endif
            ST_DONE: begin
                ovr_d   = req_any;
                done_d  = 1'b1;
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; line idles high with the pad disabled.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            shreg_q  <= '0;
            count_q  <= '0;
            beats_q  <= '0;
            serial_o <= '1;
            oe_o     <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            ovr_o    <= 1'b0;
`ifdef SER_CRC_EN
            crc_q    <= '0;
`endif
        end else begin
            shreg_q  <= shreg_d;
            count_q  <= count_d;
            beats_q  <= beats_d;
            serial_o <= serial_d;
            oe_o     <= oe_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            ovr_o    <= ovr_d;
`ifdef SER_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_sd_piso_serializer.sv
// tb_sd_piso_serializer: directed tests for the SD PISO serializer.
// Drives inputs #1 after the rising edge and samples outputs at the same point.
// CRC-specific checks are compiled only when SER_CRC_EN is defined.
`timescale 1ns/1ps
module tb_sd_piso_serializer;

`ifdef SER_CRC_EN
    localparam int EXTRA = 8;
`else
    localparam int EXTRA = 0;
`endif

    logic sd_clock = 1'b0;
    logic reset    = 1'b1;
    always #5 sd_clock = ~sd_clock;

    int checks = 0;
    int errors = 0;

    // 48-bit, single-lane instance (CMD style)
    logic        a_load  = 1'b0;
    logic        a_start = 1'b0;
    logic [47:0] a_frame = '0;
    logic [5:0]  a_beats = '0;
    logic [0:0]  a_serial;
    logic        a_oe, a_busy, a_done, a_ovr;

    sd_piso_serializer #(.FRAME_W(48), .LANES(1), .CNT_W(6), .CRC_W(7)) u_a (
        .sd_clock(sd_clock), .reset(reset), .load_i(a_load), .frame_i(a_frame),
        .start_i(a_start), .beats_i(a_beats), .serial_o(a_serial), .oe_o(a_oe),
        .busy_o(a_busy), .done_o(a_done), .ovr_o(a_ovr)
    );

    // 16-bit, four-lane instance (DAT style)
    logic        b_load  = 1'b0;
    logic        b_start = 1'b0;
    logic [15:0] b_frame = '0;
    logic [5:0]  b_beats = '0;
    logic [3:0]  b_serial;
    logic        b_oe, b_busy, b_done, b_ovr;

    sd_piso_serializer #(.FRAME_W(16), .LANES(4), .CNT_W(6), .CRC_W(7)) u_b (
        .sd_clock(sd_clock), .reset(reset), .load_i(b_load), .frame_i(b_frame),
        .start_i(b_start), .beats_i(b_beats), .serial_o(b_serial), .oe_o(b_oe),
        .busy_o(b_busy), .done_o(b_done), .ovr_o(b_ovr)
    );

`ifdef SER_CRC_EN
    // 40-bit, single-lane instance for the CRC7 vector
    logic        c_load  = 1'b0;
    logic        c_start = 1'b0;
    logic [39:0] c_frame = '0;
    logic [5:0]  c_beats = '0;
    logic [0:0]  c_serial;
    logic        c_oe, c_busy, c_done, c_ovr;

    sd_piso_serializer #(.FRAME_W(40), .LANES(1), .CNT_W(6), .CRC_W(7)) u_c (
        .sd_clock(sd_clock), .reset(reset), .load_i(c_load), .frame_i(c_frame),
        .start_i(c_start), .beats_i(c_beats), .serial_o(c_serial), .oe_o(c_oe),
        .busy_o(c_busy), .done_o(c_done), .ovr_o(c_ovr)
    );
`endif

    // Load and start in the same cycle; returns #1 after the accepting edge k.
    task automatic a_go(input logic [47:0] f, input logic [5:0] b);
        a_frame = f; a_beats = b; a_load = 1'b1; a_start = 1'b1;
        @(posedge sd_clock); #1;
        a_load = 1'b0; a_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge sd_clock);
        #1;
        checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL rst_serial got %b want 1", a_serial); end
        checks++; if (a_oe !== 1'b0) begin errors++; $display("FAIL rst_oe got %b want 0", a_oe); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", a_done); end
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", a_ovr); end
        checks++; if (b_serial !== 4'hF) begin errors++; $display("FAIL rst_serial4 got %h want f", b_serial); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid;
        int dones;
        a_go(48'hFFFF_FFFF_FFFF, 6'd0);
        repeat (5) @(posedge sd_clock);
        #1;
        checks++; if (a_oe !== 1'b1) begin errors++; $display("FAIL mid_oe_before got %b want 1", a_oe); end
        reset = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge sd_clock); #1;
            checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL mid_rst_serial%0d got %b want 1", r, a_serial); end
            checks++; if (a_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_oe%0d got %b want 0", r, a_oe); end
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy%0d got %b want 0", r, a_busy); end
        end
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge sd_clock); #1;
            if (a_done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL mid_rst_no_done got %0d pulses want 0", dones); end
    endtask

    task automatic test_cmd_frame;
        logic [47:0] f;
        f = 48'h40_0000_0000_95;
        a_go(f, 6'd0);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL cmd_busy_k got %b want 1", a_busy); end
        checks++; if (a_oe !== 1'b0) begin errors++; $display("FAIL cmd_oe_k got %b want 0", a_oe); end
        for (int c = 1; c <= 49 + EXTRA; c++) begin
            @(posedge sd_clock); #1;
            if (c <= 48) begin
                checks++; if (a_serial !== f[48-c]) begin errors++; $display("FAIL cmd_beat%0d got %b want %b", c-1, a_serial, f[48-c]); end
                checks++; if (a_oe !== 1'b1) begin errors++; $display("FAIL cmd_oe%0d got %b want 1", c-1, a_oe); end
            end else if (c <= 48 + EXTRA) begin
                checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL cmd_early_done%0d got %b want 0", c, a_done); end
            end else begin
                checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL cmd_done got %b want 1", a_done); end
                checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL cmd_busy_done got %b want 0", a_busy); end
                checks++; if (a_oe !== 1'b0) begin errors++; $display("FAIL cmd_oe_done got %b want 0", a_oe); end
                checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL cmd_idle_high got %b want 1", a_serial); end
            end
        end
        @(posedge sd_clock); #1;
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL cmd_done_pulse got %b want 0", a_done); end
    endtask

    task automatic test_saturate;
        logic [47:0] f;
        f = 48'h0000_0000_0001;
        a_go(f, 6'd49);
        for (int c = 1; c <= 49 + EXTRA; c++) begin
            @(posedge sd_clock); #1;
            if (c <= 48) begin
                checks++; if (a_serial !== f[48-c]) begin errors++; $display("FAIL sat_beat%0d got %b want %b", c-1, a_serial, f[48-c]); end
            end else if (c == 49 + EXTRA) begin
                checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL sat_done got %b want 1", a_done); end
            end else begin
                checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL sat_early_done got %b want 0", a_done); end
            end
        end
    endtask

    task automatic test_short;
        a_go(48'hC000_0000_0000, 6'd2);
        for (int c = 1; c <= 3 + EXTRA; c++) begin
            @(posedge sd_clock); #1;
            if (c <= 2) begin
                checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL short_beat%0d got %b want 1", c-1, a_serial); end
                checks++; if (a_oe !== 1'b1) begin errors++; $display("FAIL short_oe%0d got %b want 1", c-1, a_oe); end
            end else if (c == 3 + EXTRA) begin
                checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL short_done got %b want 1", a_done); end
                checks++; if (a_oe !== 1'b0) begin errors++; $display("FAIL short_oe_done got %b want 0", a_oe); end
            end else begin
                checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL short_early_done got %b want 0", a_done); end
            end
        end
        @(posedge sd_clock); #1;
        checks++; if (a_serial !== 1'b1) begin errors++; $display("FAIL short_idle got %b want 1", a_serial); end
    endtask

    task automatic test_quad;
        logic [15:0] f;
        f = 16'hA5C3;
        b_frame = f; b_beats = 6'd4; b_load = 1'b1; b_start = 1'b1;
        @(posedge sd_clock); #1;
        b_load = 1'b0; b_start = 1'b0;
        for (int c = 1; c <= 5 + EXTRA; c++) begin
            @(posedge sd_clock); #1;
            if (c <= 4) begin
                checks++; if (b_serial !== f[16-4*c +: 4]) begin errors++; $display("FAIL quad_beat%0d got %h want %h", c-1, b_serial, f[16-4*c +: 4]); end
                checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL quad_busy%0d got %b want 1", c-1, b_busy); end
            end else if (c == 5 + EXTRA) begin
                checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL quad_done got %b want 1", b_done); end
                checks++; if (b_serial !== 4'hF) begin errors++; $display("FAIL quad_idle got %h want f", b_serial); end
            end else begin
                checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL quad_early_done got %b want 0", b_done); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] f1;
        logic [47:0] f2;
        f1 = 48'h8123_4567_89AB;
        f2 = 48'h9000_0000_0000;
        a_go(f1, 6'd0);
        for (int c = 1; c <= 49 + EXTRA; c++) begin
            @(posedge sd_clock); #1;
            if (c <= 48) begin
                checks++; if (a_serial !== f1[48-c]) begin errors++; $display("FAIL ovr_beat%0d got %b want %b", c-1, a_serial, f1[48-c]); end
            end
            if (c == 6) begin
                checks++; if (a_ovr !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", a_ovr); end
                a_load = 1'b0; a_start = 1'b0;
            end
            if (c == 7) begin
                checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", a_ovr); end
                checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got %b want 1", a_busy); end
            end
            if (c == 5) begin
                a_frame = 48'hFFFF_FFFF_FFFF; a_load = 1'b1; a_start = 1'b1;
            end
        end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", a_done); end
        a_go(f2, 6'd4);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", a_busy); end
        for (int c = 1; c <= 5 + EXTRA; c++) begin
            @(posedge sd_clock); #1;
            if (c == 1) begin
                checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got %b want 0", a_ovr); end
            end
            if (c <= 4) begin
                checks++; if (a_serial !== f2[48-c]) begin errors++; $display("FAIL b2b_beat%0d got %b want %b", c-1, a_serial, f2[48-c]); end
            end else if (c == 5 + EXTRA) begin
                checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", a_done); end
            end
        end
    endtask

`ifdef SER_CRC_EN
    task automatic test_crc;
        logic [47:0] exp;
        exp = {40'h40_0000_0000, 7'b1001010, 1'b1};
        c_frame = 40'h40_0000_0000; c_beats = 6'd40; c_load = 1'b1; c_start = 1'b1;
        @(posedge sd_clock); #1;
        c_load = 1'b0; c_start = 1'b0;
        for (int c = 1; c <= 49; c++) begin
            @(posedge sd_clock); #1;
            if (c <= 48) begin
                checks++; if (c_serial !== exp[48-c]) begin errors++; $display("FAIL crc_beat%0d got %b want %b", c-1, c_serial, exp[48-c]); end
                checks++; if (c_oe !== 1'b1) begin errors++; $display("FAIL crc_oe%0d got %b want 1", c-1, c_oe); end
            end else begin
                checks++; if (c_done !== 1'b1) begin errors++; $display("FAIL crc_done got %b want 1", c_done); end
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_reset_mid;
        test_cmd_frame;
        test_saturate;
        test_short;
        test_quad;
        test_back_to_back;
`ifdef SER_CRC_EN
        test_crc;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
